// File: rtl/uart_tick_generator.sv
// Baud-rate oversampling strobe: one-cycle tick_out at BAUDRATE_HZ*SAMPLE_RATE.
// Define UART_TICK_FRAC_EN for a fractional phase accumulator (exact long-term rate).
module uart_tick_generator #(
    parameter longint unsigned BAUDRATE_HZ = 64'd115_200,
    parameter longint unsigned CLK_HZ      = 64'd100_000_000,
    parameter longint unsigned SAMPLE_RATE = 64'd16
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick_out
);

    localparam longint unsigned TICK_HZ  = BAUDRATE_HZ * SAMPLE_RATE;
    // Avoids a divide-by-zero at elaboration when the parameter check fires
    localparam longint unsigned TICK_DEN = (TICK_HZ == 64'd0) ? 64'd1 : TICK_HZ;

    if (SAMPLE_RATE < 64'd1 || BAUDRATE_HZ < 64'd1) begin : g_bad_rate
        $error("uart_tick_generator: SAMPLE_RATE and BAUDRATE_HZ must be >= 1");
    end
    if (TICK_DEN > CLK_HZ / 64'd2) begin : g_bad_div
        $error("uart_tick_generator: tick rate exceeds CLK_HZ/2 (DIV < 2)");
    end

    logic tick_q;
    logic tick_d;

    assign tick_out = tick_q;

`ifdef UART_TICK_FRAC_EN
    localparam int unsigned ACC_W = $clog2(CLK_HZ + TICK_DEN) + 1;
    localparam logic [ACC_W-1:0] TICK_INC = ACC_W'(TICK_DEN);
    localparam logic [ACC_W-1:0] CLK_LIM  = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_sum;

    // Phase accumulator: wrap by CLK_HZ and tick on every wrap
    always_comb begin
        acc_sum = acc_q + TICK_INC;
        acc_d   = acc_sum;
        tick_d  = 1'b0;
        if (acc_sum >= CLK_LIM) begin
            acc_d  = acc_sum - CLK_LIM;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end
`else
    localparam longint unsigned DIV   = (CLK_HZ + TICK_DEN / 64'd2) / TICK_DEN;
    localparam int unsigned     CNT_W = (DIV < 64'd2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 64'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Modulo-DIV counter; the tick is registered on the wrap edge
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tick_generator.sv
// Scoreboard bench for uart_tick_generator: expected tick edges are queued per run
// segment from an arithmetic rate model and matched against tick_out by a monitor.
module tb_uart_tick_generator;

    localparam longint unsigned BAUD    = 64'd115_200;
    localparam longint unsigned CLK_HZ  = 64'd100_000_000;
    localparam longint unsigned SR      = 64'd16;
    localparam longint unsigned TICK_HZ = BAUD * SR;
    localparam longint unsigned DIV     = (CLK_HZ + TICK_HZ / 64'd2) / TICK_HZ;

    logic clk_in   = 1'b0;
    logic rst_in   = 1'b1;
    logic tick_out;

    always #5 clk_in = ~clk_in;

    uart_tick_generator #(
        .BAUDRATE_HZ(BAUD),
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_RATE(SR)
    ) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tick_out(tick_out)
    );

    longint unsigned cyc      = 0;
    logic            rst_prev = 1'b1;
    logic            tick_prev = 1'b0;
    bit              armed    = 1'b0;
    longint unsigned exp_q[$];
    int              checks   = 0;
    int              failures = 0;
    int unsigned     seen_ticks = 0;

    always @(posedge clk_in) begin
        cyc      <= cyc + 64'd1;
        rst_prev <= rst_in;
    end

    // k-th non-reset edge after release carries a tick?
    function automatic bit model_tick(longint unsigned k);
`ifdef UART_TICK_FRAC_EN
        return ((k * TICK_HZ) / CLK_HZ) != (((k - 64'd1) * TICK_HZ) / CLK_HZ);
`else
        return (k % DIV) == 64'd0;
`endif
    endfunction

    // Monitor: compare tick_out against the queued expected edges every cycle
    always @(negedge clk_in) begin
        bit exp_hit;
        if (armed) begin
            if (rst_prev) begin
                checks++;
                if (tick_out !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_quiet: cycle %0d tick_out=%b required 0", cyc, tick_out);
                end
            end else begin
                exp_hit = (exp_q.size() > 0) && (exp_q[0] == cyc);
                if (exp_hit || tick_out === 1'b1) begin
                    checks++;
                    if (tick_out !== exp_hit) begin
                        failures++;
                        $display("FAIL tick_time: cycle %0d tick_out=%b required %b (next expected edge %0d)",
                                 cyc, tick_out, exp_hit, (exp_q.size() > 0) ? exp_q[0] : 64'd0);
                    end
                    if (exp_hit) void'(exp_q.pop_front());
                end
                if (tick_out === 1'b1) seen_ticks++;
            end
            if (tick_out === 1'b1) begin
                checks++;
                if (tick_prev === 1'b1) begin
                    failures++;
                    $display("FAIL pulse_width: cycle %0d tick_out high on consecutive cycles, required single-cycle", cyc);
                end
            end
            tick_prev = tick_out;
        end
    end

    task automatic do_reset(input int unsigned n);
        rst_in = 1'b1;
        repeat (n) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Free-run for len edges; queue the model's ticks and check the total count
    task automatic run(input int unsigned len);
        longint unsigned base;
        int unsigned     nexp;
        int unsigned     start;
        base  = cyc;
        nexp  = 0;
        start = seen_ticks;
        for (int unsigned k = 1; k <= len; k++) begin
            if (model_tick(64'(k))) begin
                exp_q.push_back(base + 64'(k));
                nexp++;
            end
        end
        repeat (len) @(negedge clk_in);
        #1;
        checks++;
        if (seen_ticks - start != nexp) begin
            failures++;
            $display("FAIL tick_count: %0d ticks in %0d cycles, required %0d", seen_ticks - start, len, nexp);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        @(negedge clk_in);
        armed = 1'b1;
        do_reset(1);
        run(1000);
        do_reset(1);
        run(10000);
        do_reset(1);
        run(30);
        do_reset(1);
        run(200);
        do_reset(100);
        run(300);
        for (int i = 0; i < 20; i++) begin
            do_reset($urandom_range(1, 3));
            run($urandom_range(1, 400));
        end
        do_reset(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: %0d expected ticks never seen, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
